// File: rtl/udp_report_tx.sv
// udp_report_tx: frames order-report words into a UDP-style byte stream.
// The frame is a fixed 42-byte header, a 3-byte opcode, and then either the
// payload words (big-endian) or a single 00 pad byte. The output byte is
// registered and follows AXI-Stream valid/ready rules.
module udp_report_tx #(
  parameter logic [31:0] DEST_IP   = 32'hC0A80132,
  parameter logic [15:0] SRC_PORT  = 16'd55555,
  parameter logic [7:0]  FILL_BYTE = 8'hAA,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk_udp,
  input  logic        rst_udp,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_opcode,
  input  logic        cmd_empty,
  input  logic [31:0] s_word_tdata,
  input  logic        s_word_tvalid,
  input  logic        s_word_tlast,
  output logic        s_word_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic [15:0] frames_sent
);
  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {IDLE, HDR, OPC, PAY, PAD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [5:0]      hdr_idx_q, hdr_idx_d;
  logic [1:0]      opc_idx_q, opc_idx_d;
  logic [23:0]     opcode_q, opcode_d;
  logic            empty_q, empty_d;
  logic [31:0]     word_q, word_d;     // byte holder, next byte always in [31:24]
  logic [2:0]      rem_q, rem_d;       // bytes left in the holder
  logic            wlast_q, wlast_d;   // holder word ends the frame
  logic            wtrunc_q, wtrunc_d; // ...because MAX_WORDS was reached
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     frames_q, frames_d;

  logic adv;        // output register may take a new byte this cycle
  logic word_take;
  logic new_last;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign frames_sent   = frames_q;

  function automatic logic [7:0] hdr_byte(input logic [5:0] i);
    case (i)
      6'd12:   return 8'h08;
      6'd13:   return 8'h00;
      6'd23:   return 8'h11;
      6'd30:   return DEST_IP[31:24];
      6'd31:   return DEST_IP[23:16];
      6'd32:   return DEST_IP[15:8];
      6'd33:   return DEST_IP[7:0];
      6'd34:   return SRC_PORT[15:8];
      6'd35:   return SRC_PORT[7:0];
      default: return FILL_BYTE;
    endcase
  endfunction

  // Next-state, byte sequencing and word handshake.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    opc_idx_d  = opc_idx_q;
    opcode_d   = opcode_q;
    empty_d    = empty_q;
    word_d     = word_q;
    rem_d      = rem_q;
    wlast_d    = wlast_q;
    wtrunc_d   = wtrunc_q;
    wcnt_d     = wcnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    overflow_d = overflow_q;
    frames_d   = frames_q;
    cmd_ready     = 1'b0;
    s_word_tready = 1'b0;

    adv       = !tvalid_q || m_axis_tready;
    new_last  = s_word_tlast || (wcnt_q == WCW'(MAX_WORDS - 1));
    word_take = 1'b0;

    if (tvalid_q && m_axis_tready && tlast_q) frames_d = frames_q + 16'd1;

    // Byte leaves unless a state below refills the register.
    if (adv) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Wait for the previous tlast byte to leave, so header byte 0 loads at accept.
        cmd_ready = adv;
        if (cmd_valid && adv) begin
          opcode_d  = cmd_opcode;
          empty_d   = cmd_empty;
          tdata_d   = hdr_byte(6'd0);
          tvalid_d  = 1'b1;
          hdr_idx_d = 6'd1;
          opc_idx_d = 2'd0;
          rem_d     = 3'd0;
          wlast_d   = 1'b0;
          wtrunc_d  = 1'b0;
          wcnt_d    = '0;
          state_d   = HDR;
        end
      end
      HDR: if (adv) begin
        tdata_d  = hdr_byte(hdr_idx_q);
        tvalid_d = 1'b1;
        if (hdr_idx_q == 6'd41) state_d = OPC;
        else                    hdr_idx_d = hdr_idx_q + 6'd1;
      end
      OPC: if (adv) begin
        case (opc_idx_q)
          2'd0:    tdata_d = opcode_q[23:16];
          2'd1:    tdata_d = opcode_q[15:8];
          default: tdata_d = opcode_q[7:0];
        endcase
        tvalid_d = 1'b1;
        if (opc_idx_q == 2'd2) state_d = empty_q ? PAD : PAY;
        else                   opc_idx_d = opc_idx_q + 2'd1;
      end
      PAD: if (adv) begin
        tdata_d  = 8'h00;
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        state_d  = IDLE;
      end
      PAY: begin
        // Refill when empty, or when the last held byte moves out this cycle.
        s_word_tready = (rem_q == 3'd0) || (rem_q == 3'd1 && adv && !wlast_q);
        word_take     = s_word_tready && s_word_tvalid;
        if (rem_q != 3'd0) begin
          if (adv) begin
            tdata_d  = word_q[31:24];
            tvalid_d = 1'b1;
            word_d   = {word_q[23:0], 8'h00};
            rem_d    = rem_q - 3'd1;
            if (rem_q == 3'd1 && wlast_q) begin
              tlast_d = 1'b1;
              if (wtrunc_q) begin
                overflow_d = 1'b1;
                state_d    = DRAIN;
              end else begin
                state_d    = IDLE;
              end
            end
          end
          if (word_take) begin
            word_d = s_word_tdata;
            rem_d  = 3'd4;
          end
        end else if (word_take) begin
          // Holder empty: first byte goes straight to the output to avoid a gap.
          if (adv) begin
            tdata_d  = s_word_tdata[31:24];
            tvalid_d = 1'b1;
            word_d   = {s_word_tdata[23:0], 8'h00};
            rem_d    = 3'd3;
          end else begin
            word_d   = s_word_tdata;
            rem_d    = 3'd4;
          end
        end
        if (word_take) begin
          wlast_d  = new_last;
          wtrunc_d = new_last && !s_word_tlast;
          wcnt_d   = (wcnt_q == WCW'(MAX_WORDS)) ? wcnt_q : wcnt_q + WCW'(1);
        end
      end
      DRAIN: begin
        s_word_tready = 1'b1;
        if (s_word_tvalid && s_word_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_udp or posedge rst_udp) begin
    if (rst_udp) begin
      state_q    <= IDLE;
      hdr_idx_q  <= '0;
      opc_idx_q  <= '0;
      opcode_q   <= '0;
      empty_q    <= 1'b0;
      word_q     <= '0;
      rem_q      <= '0;
      wlast_q    <= 1'b0;
      wtrunc_q   <= 1'b0;
      wcnt_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      opc_idx_q  <= opc_idx_d;
      opcode_q   <= opcode_d;
      empty_q    <= empty_d;
      word_q     <= word_d;
      rem_q      <= rem_d;
      wlast_q    <= wlast_d;
      wtrunc_q   <= wtrunc_d;
      wcnt_q     <= wcnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end
endmodule

// File: tb/tb_udp_report_tx.sv
// Bench for udp_report_tx: table of frame vectors, byte scoreboard, and
// hand-written reset-mid-frame sequence. DUT built with MAX_WORDS=4.
module tb_udp_report_tx;
  logic        clk_udp = 1'b0;
  logic        rst_udp;
  logic        cmd_valid, cmd_ready, cmd_empty;
  logic [23:0] cmd_opcode;
  logic [31:0] s_word_tdata;
  logic        s_word_tvalid, s_word_tlast, s_word_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        overflow;
  logic [15:0] frames_sent;

  udp_report_tx #(.MAX_WORDS(4)) dut (
    .clk_udp(clk_udp), .rst_udp(rst_udp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_empty(cmd_empty),
    .s_word_tdata(s_word_tdata), .s_word_tvalid(s_word_tvalid),
    .s_word_tlast(s_word_tlast), .s_word_tready(s_word_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .frames_sent(frames_sent)
  );

  always #5 clk_udp = ~clk_udp;

  typedef struct { logic [7:0] d; logic l; } byte_t;
  typedef struct { logic [31:0] d; logic l; } word_t;
  typedef struct {
    logic [23:0]  op;
    logic         empty;
    int           nw;       // words presented on s_word
    logic [191:0] w;        // word k at [191-32k -: 32]
    logic         tog;      // m_axis_tready toggles every cycle
    int           exp_len;
    logic [7:0]   exp_tail;
  } vec_t;

  byte_t exp_q[$];
  word_t wq[$];
  int    ncomp = 0, nmis = 0;
  int    bytes_seen = 0, words_taken = 0;
  int    ef = 0;
  logic  eo = 1'b0;
  logic  rdy_mode = 1'b0;
  logic [7:0] tail = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop on every transfer, stall-stability check.
  initial begin : mon
    logic ps, pl;
    logic [7:0] pd;
    byte_t e;
    ps = 1'b0; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk_udp);
      if (rst_udp) ps = 1'b0;
      else begin
        if (ps) begin
          chk("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
          chk("hold_data", {24'd0, m_axis_tdata}, {24'd0, pd});
          chk("hold_last", {31'd0, m_axis_tlast}, {31'd0, pl});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          bytes_seen++;
          if (m_axis_tlast) tail = m_axis_tdata;
          if (exp_q.size() == 0) begin
            ncomp++; nmis++;
            $display("FAIL extra_byte: got %h, expected no byte", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", {24'd0, m_axis_tdata}, {24'd0, e.d});
            chk("byte_last", {31'd0, m_axis_tlast}, {31'd0, e.l});
          end
        end
        ps = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata;
        pl = m_axis_tlast;
      end
    end
  end

  // Word source: presents wq head, pops it after a handshake.
  initial begin : feed
    logic took;
    s_word_tvalid = 1'b0; s_word_tdata = '0; s_word_tlast = 1'b0;
    forever begin
      @(negedge clk_udp);
      took = s_word_tvalid && s_word_tready && !rst_udp;
      @(posedge clk_udp); #1;
      if (took && wq.size() > 0) begin
        void'(wq.pop_front());
        words_taken++;
      end
      if (wq.size() > 0) begin
        s_word_tvalid = 1'b1; s_word_tdata = wq[0].d; s_word_tlast = wq[0].l;
      end else begin
        s_word_tvalid = 1'b0; s_word_tdata = '0; s_word_tlast = 1'b0;
      end
    end
  end

  // Downstream ready: steady or toggling.
  initial begin : rdy
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk_udp); #1;
      m_axis_tready = rdy_mode ? ~m_axis_tready : 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    nmis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nmis);
    $finish;
  end

  function automatic vec_t mk(input logic [23:0] op, input logic e, input int nw,
                              input logic [191:0] w, input logic tog, input int len,
                              input logic [7:0] tl);
    vec_t v;
    v.op = op; v.empty = e; v.nw = nw; v.w = w; v.tog = tog;
    v.exp_len = len; v.exp_tail = tl;
    return v;
  endfunction

  function automatic logic [7:0] hdr_exp(input int i);
    case (i)
      12: return 8'h08;  13: return 8'h00;  23: return 8'h11;
      30: return 8'hC0;  31: return 8'hA8;  32: return 8'h01;  33: return 8'h32;
      34: return 8'hD9;  35: return 8'h03;
      default: return 8'hAA;
    endcase
  endfunction

  task automatic push_frame(input vec_t v);
    int n;
    logic [31:0] wd;
    for (int i = 0; i < 42; i++) exp_q.push_back('{hdr_exp(i), 1'b0});
    exp_q.push_back('{v.op[23:16], 1'b0});
    exp_q.push_back('{v.op[15:8], 1'b0});
    exp_q.push_back('{v.op[7:0], 1'b0});
    if (v.empty) exp_q.push_back('{8'h00, 1'b1});
    else begin
      n = (v.nw > 4) ? 4 : v.nw;
      for (int k = 0; k < n; k++) begin
        wd = v.w[191 - 32*k -: 32];
        for (int b = 0; b < 4; b++)
          exp_q.push_back('{wd[31 - 8*b -: 8], (k == n - 1) && (b == 3)});
      end
    end
    for (int k = 0; k < v.nw; k++) wq.push_back('{v.w[191 - 32*k -: 32], k == v.nw - 1});
  endtask

  task automatic issue_cmd(input logic [23:0] op, input logic e);
    int n;
    @(posedge clk_udp); #2;
    cmd_opcode = op; cmd_empty = e; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk_udp);
    while (!cmd_ready && n < 100) begin
      @(negedge clk_udp);
      n++;
    end
    if (n >= 100) begin
      nmis++; ncomp++;
      $display("FAIL cmd_timeout: cmd_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk_udp); #2;
    cmd_valid = 1'b0;
    chk("first_byte_valid", {31'd0, m_axis_tvalid}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int b0, w0, n;
    b0 = bytes_seen; w0 = words_taken;
    rdy_mode = v.tog;
    push_frame(v);
    issue_cmd(v.op, v.empty);
    n = 0;
    while ((exp_q.size() > 0 || (!v.empty && wq.size() > 0)) && n < 3000) begin
      @(posedge clk_udp);
      n++;
    end
    if (n >= 3000) begin
      nmis++; ncomp++;
      $display("FAIL frame_timeout: %0d bytes outstanding, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk_udp);
    #2;
    ef++;
    if (!v.empty && v.nw > 4) eo = 1'b1;
    chk("byte_count", bytes_seen - b0, v.exp_len);
    chk("tail_byte", {24'd0, tail}, {24'd0, v.exp_tail});
    chk("words_taken", words_taken - w0, v.empty ? 0 : v.nw);
    chk("frames_sent", {16'd0, frames_sent}, ef);
    chk("overflow", {31'd0, overflow}, {31'd0, eo});
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    wq.delete();
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk_udp);
  endtask

  initial begin : main
    vec_t tbl[7];
    vec_t vr;
    int b0, n;
    tbl[0] = mk(24'h102030, 1'b0, 1, {32'h0069000A, 160'd0}, 1'b0, 49, 8'h0A);
    tbl[1] = mk(24'hF0E0D0, 1'b1, 1, {32'hDEADBEEF, 160'd0}, 1'b0, 46, 8'h00);
    tbl[2] = mk(24'hABCDEF, 1'b0, 3, {32'h11223344, 32'h55667788, 32'h99AABBCC, 96'd0}, 1'b0, 57, 8'hCC);
    tbl[3] = mk(24'hABCDEF, 1'b0, 3, {32'h11223344, 32'h55667788, 32'h99AABBCC, 96'd0}, 1'b1, 57, 8'hCC);
    tbl[4] = mk(24'h445566, 1'b0, 4, {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4, 64'd0}, 1'b1, 61, 8'hD4);
    tbl[5] = mk(24'h0A0B0C, 1'b0, 6, {32'h01020304, 32'h05060708, 32'h090A0B0C,
                                      32'h0D0E0F10, 32'h11121314, 32'h15161718}, 1'b0, 61, 8'h10);
    tbl[6] = mk(24'h7F8001, 1'b1, 0, 192'd0, 1'b1, 46, 8'h00);

    cmd_valid = 1'b0; cmd_opcode = '0; cmd_empty = 1'b0;
    rst_udp = 1'b1;
    repeat (3) @(posedge clk_udp);
    #2;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_s_tready", {31'd0, s_word_tready}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frames", {16'd0, frames_sent}, 32'd0);
    rst_udp = 1'b0;
    #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Reset while header byte 20 is being sent, then a clean frame.
    vr = mk(24'h010203, 1'b1, 0, 192'd0, 1'b0, 46, 8'h00);
    b0 = bytes_seen;
    push_frame(vr);
    issue_cmd(vr.op, vr.empty);
    n = 0;
    while (bytes_seen - b0 < 21 && n < 200) begin
      @(posedge clk_udp);
      n++;
    end
    #3;
    rst_udp = 1'b1;
    #1;
    chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("midrst_frames", {16'd0, frames_sent}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    ef = 0; eo = 1'b0;
    @(posedge clk_udp); #2;
    rst_udp = 1'b0;
    repeat (2) @(posedge clk_udp);
    run_vec(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nmis);
    $finish;
  end
endmodule
